srb_update_sched: RTL and testbench
===================================

# srb_update_sched

Update scheduler and arbiter for the 16-bit serial shift-register B output word. Several control requesters (interlock logic, host register writes, sequencer) each issue masked bit updates. The block merges them round-robin into a shadow word and commits that word only on a frame boundary of the free-running SRB serializer, so no 16-bit frame is ever shifted out torn. It sits between the requesters and the serializer's `out0..out15` inputs, and reports back to each requester when its update has physically been strobed out.

## Interface
Parameters:
- `NREQ`, 4: number of requesters (2..8).
- `RESET_WORD`, 16'h0000: value of the output word after reset.

Ports:
- `CLK_IN`  in  1  system clock; also clocks the serializer.
- `RST_N`  in  1  asynchronous, active-low reset.
- `FRAME_TICK`  in  1  one-cycle pulse from the serializer when its bit counter is at its idle/reload slot (frame boundary). Nominal period 17 cycles; the block must not depend on the period.
- `REQ`  in  NREQ  per-requester update request; level, held until `GNT`.
- `WMASK`  in  16*NREQ  per-requester bit mask, 1 = bit is written. Slice i = bits [16i+15:16i].
- `WDATA`  in  16*NREQ  per-requester bit values; only masked bits are used.
- `GNT`  out  NREQ  one-cycle pulse: update merged into the shadow word.
- `DONE`  out  NREQ  one-cycle pulse: the frame containing that update has completed and been strobed.
- `SR_WORD`  out  16  active word, drives serializer `out0..out15` (bit k → `outk`).
- `PENDING`  out  1  shadow word holds uncommitted updates.
- `FRAME_CNT`  out  16  number of commits, wraps modulo 2^16.
- `CONFLICT`  out  NREQ  sticky conflict flags; present only with `SRB_SCHED_CONFLICT_EN`.

## Operation
- Reset values:
  - `SR_WORD` = `RESET_WORD`; shadow = `RESET_WORD`.
  - `GNT`, `DONE`, `PENDING`, `FRAME_CNT`, `CONFLICT` = 0.
  - Round-robin pointer = 0; state = IDLE.
- Arbitration:
  - At most one grant per cycle, round-robin starting from the requester after the last grantee.
  - Grant applies `shadow <= (shadow & ~WMASK[i]) | (WDATA[i] & WMASK[i])`.
  - Sets `PENDING` and sets bit i of the `merged` set.
  - A request with `WMASK` = 0 is still granted and still receives `DONE`.
- FSM states:
  - IDLE: no pending updates. Go to MERGE on the first grant.
  - MERGE: accepting grants. On `FRAME_TICK` go to COMMIT.
  - COMMIT (1 cycle):
    - `SR_WORD <= shadow`; `inflight <= merged`; `merged <= 0`; `FRAME_CNT++`; clear `PENDING`.
    - Go to SHIFT.
  - SHIFT: grants continue into shadow (they set `PENDING` and `merged` again). On the next `FRAME_TICK`:
    - pulse `DONE = inflight`; clear `inflight`.
    - If `merged` ≠ 0, commit in that same cycle (act as COMMIT) and stay in SHIFT; otherwise go to IDLE.
- A commit happens only when `merged` ≠ 0. If nothing is pending, `FRAME_TICK` has no effect.
- Boundary rules:
  - Grant in the same cycle as `FRAME_TICK`: the commit uses the shadow value from before that grant. The grant is counted in the next frame's `merged`, not the current `inflight`.
  - A requester granted twice within one frame gets a single `DONE`.
  - `REQ` deasserted before `GNT`: the request is withdrawn with no effect.
  - `RST_N` asserted mid-frame: outputs return to reset values immediately. `inflight` requesters never receive `DONE`.

## Timing
- `GNT` is registered: it asserts the cycle after `REQ` is sampled, when there is no competition.
- Worst-case grant latency is NREQ cycles.
- `SR_WORD` updates on the rising edge after the cycle in which `FRAME_TICK` is high, i.e. in the serializer's bit-0 load slot.
- `SR_WORD` is stable for the full frame.
- `DONE` follows `GNT` by one to two frame periods.

## Configuration
- `SRB_SCHED_CONFLICT_EN` defined:
  - Tracks a per-bit writer mask and written value for the current `merged` frame.
  - A grant that writes a bit already written this frame by a different requester, with a different value, sets sticky `CONFLICT[i]` for the later writer. The last write still wins.
  - `CONFLICT` is cleared only by reset.
- Not defined: no tracking logic is built; `CONFLICT` is tied to 0.

## Structure
- Package `srb_sched_pkg`:
  - `SRB_WIDTH` = 16.
  - `SRB_FRAME_LEN` = 17.
  - FSM state enum {IDLE, MERGE, COMMIT, SHIFT}.
- Sub-module `srb_rr_arbiter`: parameterized NREQ round-robin arbiter. Inputs: request vector and pointer. Outputs: one-hot grant and next pointer.

## Test plan
- Reset with `RESET_WORD` = 16'hA5A5 → `SR_WORD` = A5A5, all flags 0. Send a single `REQ[0]` (mask 000F, data 0003), then tick → `SR_WORD` = A5A3 and `FRAME_CNT` = 1; `DONE[0]` pulses on the following tick.
- All four `REQ` high simultaneously, each writing a distinct nibble → `GNT` arrives in order 0,1,2,3 on consecutive cycles; one commit carries all four nibbles; four `DONE` pulses land on the same cycle.
- Grant coincident with `FRAME_TICK` → excluded from that commit; applied at the next tick with a separate `DONE`.
- Ticks with no requests, 20 frames → `SR_WORD` and `FRAME_CNT` unchanged.
- With `SRB_SCHED_CONFLICT_EN`: requester 1 writes bit 3 = 1, then requester 2 writes bit 3 = 0 in the same frame → `CONFLICT` = 0100 and `SR_WORD[3]` = 0. The same sequence without the macro → `CONFLICT` = 0.
- Assert `RST_N` low while in SHIFT → immediate reset values; no `DONE` pulse after release.

Source files
------------

// File: rtl/srb_sched_pkg.sv
// Shared constants and FSM state type for the SRB update scheduler.
package srb_sched_pkg;

  localparam int SRB_WIDTH     = 16;
  localparam int SRB_FRAME_LEN = 17;

  typedef enum logic [1:0] {
    IDLE,
    MERGE,
    COMMIT,
    SHIFT
  } sched_state_t;

endpackage

// File: rtl/srb_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after ptr,
// and the pointer value that makes the grantee lowest priority next time.
module srb_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [PW-1:0]   next_ptr
);

  logic [PW-1:0] idx;

  // Scan from farthest to nearest so the requester closest to ptr wins.
  always_comb begin
    gnt      = '0;
    next_ptr = ptr;
    idx      = ptr;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = PW'((int'(ptr) + k) % NREQ);
      if (req[idx]) begin
        gnt      = '0;
        gnt[idx] = 1'b1;
        next_ptr = (int'(idx) == NREQ - 1) ? '0 : idx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/srb_update_sched.sv
// Merges masked requester updates into a shadow word and commits it to the SRB
// serializer only on frame boundaries. Optional conflict tracking: SRB_SCHED_CONFLICT_EN.
module srb_update_sched
  import srb_sched_pkg::*;
#(
  parameter int                   NREQ       = 4,
  parameter logic [SRB_WIDTH-1:0] RESET_WORD = 16'h0000
) (
  input  logic                      CLK_IN,
  input  logic                      RST_N,
  input  logic                      FRAME_TICK,
  input  logic [NREQ-1:0]           REQ,
  input  logic [SRB_WIDTH*NREQ-1:0] WMASK,
  input  logic [SRB_WIDTH*NREQ-1:0] WDATA,
  output logic [NREQ-1:0]           GNT,
  output logic [NREQ-1:0]           DONE,
  output logic [SRB_WIDTH-1:0]      SR_WORD,
  output logic                      PENDING,
  output logic [15:0]               FRAME_CNT,
  output logic [NREQ-1:0]           CONFLICT
);

  localparam int PW = $clog2(NREQ);

  sched_state_t         state;
  logic [PW-1:0]        rr_ptr;
  logic [PW-1:0]        rr_next;
  logic [NREQ-1:0]      arb_req;
  logic [NREQ-1:0]      arb_gnt;
  logic [NREQ-1:0]      merged;
  logic [NREQ-1:0]      inflight;
  logic [SRB_WIDTH-1:0] shadow;
  logic [SRB_WIDTH-1:0] grant_mask;
  logic [SRB_WIDTH-1:0] grant_data;
  logic                 grant_any;
  logic                 commit;
  logic                 done_fire;

  // A requester still showing GNT is excluded so a registered requester that
  // drops REQ one edge late is not granted twice for the same update.
  assign arb_req = REQ & ~GNT;

  srb_rr_arbiter #(
    .NREQ(NREQ),
    .PW  (PW)
  ) u_arb (
    .req     (arb_req),
    .ptr     (rr_ptr),
    .gnt     (arb_gnt),
    .next_ptr(rr_next)
  );

  always_comb begin
    grant_mask = '0;
    grant_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_gnt[i]) begin
        grant_mask = WMASK[i*SRB_WIDTH +: SRB_WIDTH];
        grant_data = WDATA[i*SRB_WIDTH +: SRB_WIDTH];
      end
    end
  end

  assign grant_any = |arb_gnt;
  assign commit    = FRAME_TICK && (|merged);
  assign done_fire = FRAME_TICK && (state == COMMIT || state == SHIFT);

  // A grant on the commit edge lands in the new merged set; the commit
  // itself sees the pre-grant shadow through non-blocking semantics.
  always_ff @(posedge CLK_IN or negedge RST_N) begin
    if (!RST_N) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      shadow    <= RESET_WORD;
      SR_WORD   <= RESET_WORD;
      merged    <= '0;
      inflight  <= '0;
      GNT       <= '0;
      DONE      <= '0;
      PENDING   <= 1'b0;
      FRAME_CNT <= '0;
    end else begin
      GNT     <= arb_gnt;
      DONE    <= '0;
      merged  <= (commit ? '0 : merged) | arb_gnt;
      PENDING <= (commit ? 1'b0 : PENDING) | grant_any;
      if (grant_any) begin
        shadow <= (shadow & ~grant_mask) | (grant_data & grant_mask);
        rr_ptr <= rr_next;
      end
      if (done_fire) begin
        DONE     <= inflight;
        inflight <= '0;
      end
      if (commit) begin
        SR_WORD   <= shadow;
        inflight  <= merged;
        FRAME_CNT <= FRAME_CNT + 16'd1;
      end
      case (state)
        IDLE:   if (grant_any) state <= MERGE;
        MERGE:  if (FRAME_TICK) state <= COMMIT;
        COMMIT, SHIFT: begin
          if (FRAME_TICK && !commit) state <= grant_any ? MERGE : IDLE;
          else                       state <= SHIFT;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SRB_SCHED_CONFLICT_EN
  logic [SRB_WIDTH-1:0] wr_seen;
  logic [SRB_WIDTH-1:0] wr_val;
  logic [PW-1:0]        wr_owner [SRB_WIDTH];
  logic [PW-1:0]        gnt_idx;
  logic [NREQ-1:0]      conflict_q;
  logic                 clash;

  // Writer history belongs to the merged frame, so a grant on a commit edge
  // is compared against an empty history.
  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_gnt[i]) gnt_idx = PW'(i);
    end
    clash = 1'b0;
    for (int b = 0; b < SRB_WIDTH; b++) begin
      if (!commit && grant_mask[b] && wr_seen[b] && wr_owner[b] != gnt_idx &&
          wr_val[b] != grant_data[b]) clash = 1'b1;
    end
  end

  always_ff @(posedge CLK_IN or negedge RST_N) begin
    if (!RST_N) begin
      wr_seen    <= '0;
      wr_val     <= '0;
      conflict_q <= '0;
      for (int b = 0; b < SRB_WIDTH; b++) wr_owner[b] <= '0;
    end else begin
      if (grant_any && clash) conflict_q[gnt_idx] <= 1'b1;
      for (int b = 0; b < SRB_WIDTH; b++) begin
        if (grant_mask[b]) begin
          wr_seen[b]  <= 1'b1;
          wr_val[b]   <= grant_data[b];
          wr_owner[b] <= gnt_idx;
        end else if (commit) begin
          wr_seen[b] <= 1'b0;
        end
      end
    end
  end

  assign CONFLICT = conflict_q;
`else
  assign CONFLICT = '0;
`endif

endmodule

// File: tb/tb_srb_update_sched.sv
// Self-checking bench for srb_update_sched: frame-level reference model plus
// directed scenarios with hand-computed word, count and DONE expectations.
module tb_srb_update_sched;

  localparam int NREQ = 4;
`ifdef SRB_SCHED_CONFLICT_EN
  localparam logic [3:0] EXP_CONF = 4'b0100;
`else
  localparam logic [3:0] EXP_CONF = 4'b0000;
`endif

  logic        CLK_IN = 1'b0;
  logic        RST_N = 1'b0;
  logic        FRAME_TICK = 1'b0;
  logic [3:0]  REQ = '0;
  logic [63:0] WMASK = '0;
  logic [63:0] WDATA = '0;
  logic [3:0]  GNT;
  logic [3:0]  DONE;
  logic [15:0] SR_WORD;
  logic        PENDING;
  logic [15:0] FRAME_CNT;
  logic [3:0]  CONFLICT;

  int vectors = 0;
  int miscompares = 0;

  srb_update_sched #(
    .NREQ      (NREQ),
    .RESET_WORD(16'hA5A5)
  ) dut (
    .CLK_IN    (CLK_IN),
    .RST_N     (RST_N),
    .FRAME_TICK(FRAME_TICK),
    .REQ       (REQ),
    .WMASK     (WMASK),
    .WDATA     (WDATA),
    .GNT       (GNT),
    .DONE      (DONE),
    .SR_WORD   (SR_WORD),
    .PENDING   (PENDING),
    .FRAME_CNT (FRAME_CNT),
    .CONFLICT  (CONFLICT)
  );

  always #5 CLK_IN = ~CLK_IN;

  // Reference model: the shifted-out word, the set of requesters merged into
  // the next frame, and the set whose frame is currently on the wire.
  logic [15:0] m_shadow, m_word, m_cnt, m_val;
  logic [3:0]  m_merged, m_inflight, m_gnt, m_done, m_conf;
  int          m_ptr;
  int          m_owner [16];

  task automatic model_reset();
    m_shadow = 16'hA5A5; m_word = 16'hA5A5; m_cnt = '0; m_val = '0;
    m_merged = '0; m_inflight = '0; m_gnt = '0; m_done = '0; m_conf = '0;
    m_ptr = 0;
    for (int b = 0; b < 16; b++) m_owner[b] = -1;
  endtask

  task automatic model_step();
    logic [1:0]  gi;
    logic        found;
    logic [15:0] mk, dt;
    gi = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      logic [1:0] cand;
      cand = 2'(m_ptr + k);
      if (!found && REQ[cand]) begin
        found = 1'b1;
        gi = cand;
      end
    end
    m_done = FRAME_TICK ? m_inflight : 4'b0000;
    if (FRAME_TICK && m_merged != 4'b0000) begin
      m_word = m_shadow;
      m_cnt = m_cnt + 16'd1;
      m_inflight = m_merged;
      m_merged = '0;
      for (int b = 0; b < 16; b++) m_owner[b] = -1;
    end else if (FRAME_TICK) begin
      m_inflight = '0;
    end
    m_gnt = '0;
    if (found) begin
      mk = 16'(WMASK >> (16 * int'(gi)));
      dt = 16'(WDATA >> (16 * int'(gi)));
      for (int b = 0; b < 16; b++) begin
        if (mk[b]) begin
          if (m_owner[b] >= 0 && m_owner[b] != int'(gi) && m_val[b] != dt[b]) m_conf[gi] = 1'b1;
          m_owner[b] = int'(gi);
          m_val[b] = dt[b];
        end
      end
      m_shadow = (m_shadow & ~mk) | (dt & mk);
      m_gnt[gi] = 1'b1;
      m_merged = m_merged | m_gnt;
      m_ptr = (int'(gi) + 1) % NREQ;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge CLK_IN or negedge RST_N);
      if (!RST_N) model_reset();
      else        model_step();
    end
  end

  task automatic check_output(input string name, input logic [15:0] actual,
                              input logic [15:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Every cycle the DUT outputs are compared against the model.
  initial begin
    forever begin
      @(negedge CLK_IN);
      check_output("cyc_gnt", 16'(GNT), 16'(m_gnt));
      check_output("cyc_done", 16'(DONE), 16'(m_done));
      check_output("cyc_word", SR_WORD, m_word);
      check_output("cyc_pending", 16'(PENDING), 16'(m_merged != 4'b0000));
      check_output("cyc_cnt", FRAME_CNT, m_cnt);
      check_output("cyc_conflict", 16'(CONFLICT), 16'(m_conf & EXP_CONF | (EXP_CONF == 4'b0000 ? 4'b0000 : m_conf)));
    end
  end

  task automatic apply_stimulus(input logic tick);
    @(negedge CLK_IN);
    REQ = REQ & ~GNT;
    FRAME_TICK = tick;
  endtask

  task automatic idle(input int n);
    repeat (n) apply_stimulus(1'b0);
  endtask

  task automatic tick_now();
    apply_stimulus(1'b1);
    apply_stimulus(1'b0);
  endtask

  task automatic post_req(input logic [1:0] i, input logic [15:0] m, input logic [15:0] d);
    int sh;
    sh = 16 * int'(i);
    WMASK = (WMASK & ~(64'hFFFF << sh)) | ({48'b0, m} << sh);
    WDATA = (WDATA & ~(64'hFFFF << sh)) | ({48'b0, d} << sh);
    REQ[i] = 1'b1;
  endtask

  task automatic do_reset();
    #2;
    RST_N = 1'b0;
    REQ = '0;
    FRAME_TICK = 1'b0;
    WMASK = '0;
    WDATA = '0;
    #1;
    check_output("rst_word", SR_WORD, 16'hA5A5);
    check_output("rst_cnt", FRAME_CNT, 16'h0000);
    check_output("rst_pending", 16'(PENDING), 16'h0000);
    check_output("rst_gnt", 16'(GNT), 16'h0000);
    check_output("rst_done", 16'(DONE), 16'h0000);
    check_output("rst_conflict", 16'(CONFLICT), 16'h0000);
    @(negedge CLK_IN);
    @(negedge CLK_IN);
    #2;
    RST_N = 1'b1;
  endtask

  initial begin
    @(negedge CLK_IN);
    do_reset();

    // Single requester: A5A5 with low nibble 3 -> A5A3.
    apply_stimulus(1'b0);
    post_req(2'd0, 16'h000F, 16'h0003);
    idle(2);
    tick_now();
    check_output("s1_word", SR_WORD, 16'hA5A3);
    check_output("s1_cnt", FRAME_CNT, 16'd1);
    check_output("s1_pending", 16'(PENDING), 16'h0000);
    idle(15);
    tick_now();
    check_output("s1_done", 16'(DONE), 16'h0001);
    idle(15);

    // Four simultaneous requesters, one nibble each.
    do_reset();
    apply_stimulus(1'b0);
    post_req(2'd0, 16'h000F, 16'h000A);
    post_req(2'd1, 16'h00F0, 16'h00B0);
    post_req(2'd2, 16'h0F00, 16'h0C00);
    post_req(2'd3, 16'hF000, 16'hD000);
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(1'b0);
      check_output("s2_gnt_order", 16'(GNT), 16'h0001 << i);
    end
    tick_now();
    check_output("s2_word", SR_WORD, 16'hDCBA);
    check_output("s2_cnt", FRAME_CNT, 16'd1);
    idle(15);
    tick_now();
    check_output("s2_done_all", 16'(DONE), 16'h000F);
    idle(15);

    // Grant on the tick edge is excluded from that commit.
    apply_stimulus(1'b0);
    post_req(2'd0, 16'h00F0, 16'h0010);
    idle(2);
    apply_stimulus(1'b1);
    post_req(2'd1, 16'h0F00, 16'h0200);
    apply_stimulus(1'b0);
    check_output("s3_gnt", 16'(GNT), 16'h0002);
    check_output("s3_word", SR_WORD, 16'hDC1A);
    check_output("s3_pending", 16'(PENDING), 16'h0001);
    check_output("s3_cnt", FRAME_CNT, 16'd2);
    idle(15);
    tick_now();
    check_output("s3_done_first", 16'(DONE), 16'h0001);
    check_output("s3_word2", SR_WORD, 16'hD21A);
    check_output("s3_cnt2", FRAME_CNT, 16'd3);
    idle(15);
    tick_now();
    check_output("s3_done_second", 16'(DONE), 16'h0002);
    idle(15);

    // Twenty empty frames change nothing.
    repeat (20) begin
      tick_now();
      idle(15);
    end
    check_output("s4_word", SR_WORD, 16'hD21A);
    check_output("s4_cnt", FRAME_CNT, 16'd3);
    check_output("s4_pending", 16'(PENDING), 16'h0000);

    // Bit 3 written 1 by requester 1, then 0 by requester 2; requester 1 again with empty mask.
    apply_stimulus(1'b0);
    post_req(2'd1, 16'h0008, 16'h0008);
    idle(2);
    post_req(2'd2, 16'h0008, 16'h0000);
    idle(2);
    post_req(2'd1, 16'h0000, 16'h0000);
    idle(2);
    check_output("s5_conflict", 16'(CONFLICT), 16'(EXP_CONF));
    tick_now();
    check_output("s5_word", SR_WORD, 16'hD212);
    check_output("s5_cnt", FRAME_CNT, 16'd4);
    idle(15);
    tick_now();
    check_output("s5_done_once", 16'(DONE), 16'h0006);
    idle(15);

    // Reset while a frame is in flight: no DONE afterwards.
    apply_stimulus(1'b0);
    post_req(2'd0, 16'hFFFF, 16'h1234);
    idle(2);
    tick_now();
    check_output("s6_word", SR_WORD, 16'h1234);
    idle(5);
    do_reset();
    repeat (2) begin
      tick_now();
      check_output("s6_no_done", 16'(DONE), 16'h0000);
      idle(15);
    end

    // Requester 1 withdraws before being granted; requester 0 has an empty mask.
    apply_stimulus(1'b0);
    post_req(2'd0, 16'h0000, 16'h0000);
    post_req(2'd1, 16'hFFFF, 16'h0000);
    apply_stimulus(1'b0);
    check_output("s7_gnt", 16'(GNT), 16'h0001);
    REQ[1] = 1'b0;
    idle(3);
    check_output("s7_pending", 16'(PENDING), 16'h0001);
    tick_now();
    check_output("s7_word", SR_WORD, 16'hA5A5);
    check_output("s7_cnt", FRAME_CNT, 16'd1);
    idle(15);
    tick_now();
    check_output("s7_done", 16'(DONE), 16'h0001);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
